branch_resolve_unit: RTL and testbench

//  EX-stage branch resolver, the consumer of the branch fields carried by the ID/EX register.
//  - Compares the forwarded operands and decides whether the branch is taken.
//  - Checks that decision against the prediction carried down the pipe.
//  - On a mismatch, drives flush_o back to the IF/ID and ID/EX registers and redirects the PC.
//  - Owns the 2-bit saturating predictor whose output feeds the ID/EX prediction input.

---
 rtl/branch_pkg.sv | 15 +
 rtl/bp_sat_counter.sv | 38 +++
 rtl/branch_resolve_unit.sv | 72 +++++++
 tb/tb_branch_resolve_unit.sv | 118 +++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the EX-stage branch resolver: predictor states and
// the branch funct3 values it understands.
package branch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_state_e;

  localparam logic [2:0] BEQ = 3'b000;
  localparam logic [2:0] BNE = 3'b001;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating branch predictor state machine with a synchronous reset.
module bp_sat_counter
  import branch_pkg::*;
#(
  parameter logic [1:0] INIT_STATE = 2'b11
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       inc_i,
  output logic [1:0] state_o
);

  bp_state_e state_reg;
  bp_state_e state_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= bp_state_e'(INIT_STATE);
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (en_i) begin
      if (inc_i) begin
        if (state_reg != ST) state_next = bp_state_e'(state_reg + 2'd1);
      end else begin
        if (state_reg != SNT) state_next = bp_state_e'(state_reg - 2'd1);
      end
    end
  end

  assign state_o = state_reg;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: decides the outcome, flags mispredictions with a
// same-cycle flush/redirect, and trains the 2-bit predictor feeding ID.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter logic [1:0] INIT_STATE = 2'b11,
  parameter int         CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             pred_o,
  input  logic             ex_branch_i,
  input  logic             ex_prev_pred_i,
  input  logic [2:0]       ex_funct3_i,
  input  logic [31:0]      ex_rs1data_i,
  input  logic [31:0]      ex_rs2data_i,
  input  logic [31:0]      ex_pc_next_i,
  input  logic [31:0]      ex_beq_tar_i,
  output logic             flush_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  logic             ops_equal;
  logic             taken;
  logic             mis;
  logic [1:0]       state;
  logic [CNT_W-1:0] br_cnt_reg;
  logic [CNT_W-1:0] mispred_cnt_reg;

  assign ops_equal = (ex_rs1data_i == ex_rs2data_i);
  assign taken = ex_branch_i & (((ex_funct3_i == BEQ) & ops_equal) |
                                ((ex_funct3_i == BNE) & ~ops_equal));

  // A branch caught by reset is dropped, so it must not flush or redirect.
  assign mis = ~rst_i & ex_branch_i & (taken != ex_prev_pred_i);

  assign flush_o       = mis;
  assign redirect_o    = mis;
  assign redirect_pc_o = mis ? (taken ? ex_beq_tar_i : ex_pc_next_i) : 32'h0;

  bp_sat_counter #(
    .INIT_STATE(INIT_STATE)
  ) u_pred (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (ex_branch_i),
    .inc_i  (taken),
    .state_o(state)
  );

  // ID reads the pre-update state; during reset it sees the reset prediction.
  assign pred_o  = rst_i ? INIT_STATE[1] : state[1];
  assign state_o = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_reg      <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      if (ex_branch_i) br_cnt_reg <= br_cnt_reg + CNT_W'(1);
      if (mis) mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
    end
  end

  assign br_cnt_o      = br_cnt_reg;
  assign mispred_cnt_o = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit, plus a CNT_W=2 copy for wrap.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_branch_i;
  logic        ex_prev_pred_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_rs1data_i;
  logic [31:0] ex_rs2data_i;
  logic [31:0] ex_pc_next_i;
  logic [31:0] ex_beq_tar_i;

  logic        pred_o, flush_o, redirect_o;
  logic [31:0] redirect_pc_o;
  logic [1:0]  state_o;
  logic [15:0] br_cnt_o, mispred_cnt_o;

  logic        w_pred, w_flush, w_redirect;
  logic [31:0] w_redirect_pc;
  logic [1:0]  w_state;
  logic [1:0]  w_br_cnt, w_mispred_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  branch_resolve_unit #(.INIT_STATE(2'b11), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pred_o(pred_o),
    .ex_branch_i(ex_branch_i), .ex_prev_pred_i(ex_prev_pred_i),
    .ex_funct3_i(ex_funct3_i), .ex_rs1data_i(ex_rs1data_i),
    .ex_rs2data_i(ex_rs2data_i), .ex_pc_next_i(ex_pc_next_i),
    .ex_beq_tar_i(ex_beq_tar_i), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .state_o(state_o),
    .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  branch_resolve_unit #(.INIT_STATE(2'b11), .CNT_W(2)) dut_w (
    .clk_i(clk_i), .rst_i(rst_i), .pred_o(w_pred),
    .ex_branch_i(ex_branch_i), .ex_prev_pred_i(ex_prev_pred_i),
    .ex_funct3_i(ex_funct3_i), .ex_rs1data_i(ex_rs1data_i),
    .ex_rs2data_i(ex_rs2data_i), .ex_pc_next_i(ex_pc_next_i),
    .ex_beq_tar_i(ex_beq_tar_i), .flush_o(w_flush), .redirect_o(w_redirect),
    .redirect_pc_o(w_redirect_pc), .state_o(w_state),
    .br_cnt_o(w_br_cnt), .mispred_cnt_o(w_mispred_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, then registered ones.
  task automatic vec(input string tag, input logic rst, input logic br,
                     input logic prev, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pcn, input logic [31:0] tar,
                     input logic e_flush, input logic [31:0] e_pc,
                     input logic e_pred, input logic [1:0] e_state,
                     input logic [15:0] e_br, input logic [15:0] e_mis);
    @(negedge clk_i);
    rst_i = rst; ex_branch_i = br; ex_prev_pred_i = prev; ex_funct3_i = f3;
    ex_rs1data_i = a; ex_rs2data_i = b; ex_pc_next_i = pcn; ex_beq_tar_i = tar;
    #1;
    check_val({tag, ".flush"}, 32'(flush_o), 32'(e_flush));
    check_val({tag, ".redir"}, 32'(redirect_o), 32'(e_flush));
    check_val({tag, ".pc"}, redirect_pc_o, e_pc);
    check_val({tag, ".pred"}, 32'(pred_o), 32'(e_pred));
    @(posedge clk_i);
    #1;
    check_val({tag, ".state"}, 32'(state_o), 32'(e_state));
    check_val({tag, ".brcnt"}, 32'(br_cnt_o), 32'(e_br));
    check_val({tag, ".miscnt"}, 32'(mispred_cnt_o), 32'(e_mis));
    $display("vec %-8s rst=%0b br=%0b f3=%0d flush=%0b pc=%08h state=%0d br_cnt=%0d mis_cnt=%0d",
             tag, rst, br, f3, flush_o, redirect_pc_o, state_o, br_cnt_o, mispred_cnt_o);
  endtask

  initial begin
    rst_i = 1'b1; ex_branch_i = 1'b0; ex_prev_pred_i = 1'b0; ex_funct3_i = 3'b000;
    ex_rs1data_i = '0; ex_rs2data_i = '0; ex_pc_next_i = '0; ex_beq_tar_i = '0;

    //     tag       rst br pr f3      rs1  rs2  pc_next  target   fl pc      pd st  br  mis
    vec("reset",     1, 0, 0, 3'b000, 0,   0,   0,       0,       0, 0,      1, 3,  0,  0);
    vec("t1_beq",    0, 1, 1, BEQ,    5,   5,   'h104,   'h200,   0, 0,      1, 3,  1,  0);
    vec("t2_mis",    0, 1, 1, BEQ,    1,   2,   'h104,   'h200,   1, 'h104,  1, 2,  2,  1);
    vec("t3_up",     0, 1, 1, BEQ,    4,   4,   'h108,   'h300,   0, 0,      1, 3,  3,  1);
    vec("t3_nt0",    0, 1, 0, BEQ,    1,   3,   'h10c,   'h300,   0, 0,      1, 2,  4,  1);
    vec("t3_nt1",    0, 1, 0, BEQ,    1,   3,   'h10c,   'h300,   0, 0,      1, 1,  5,  1);
    vec("t3_nt2",    0, 1, 0, BEQ,    1,   3,   'h10c,   'h300,   0, 0,      0, 0,  6,  1);
    vec("t3_nt3",    0, 1, 0, BEQ,    1,   3,   'h10c,   'h300,   0, 0,      0, 0,  7,  1);
    vec("t3_tk",     0, 1, 0, BEQ,    9,   9,   'h204,   'h300,   1, 'h300,  0, 1,  8,  2);
    vec("t4_bne",    0, 1, 0, BNE,    7,   7,   'h404,   'h500,   0, 0,      0, 0,  9,  2);
    vec("t4_bnetk",  0, 1, 1, BNE,    7,   8,   'h408,   'h600,   0, 0,      0, 1, 10,  2);
    vec("t4_f3x",    0, 1, 1, 3'b100, 6,   6,   'h40c,   'h700,   1, 'h40c,  0, 0, 11,  3);

    for (int i = 0; i < 10; i++) begin
      vec("t5_bub",  0, 0, 1'($urandom), 3'($urandom), $urandom, $urandom,
          $urandom, $urandom,                                     0, 0,      0, 0, 11,  3);
    end

    vec("t6_rst",    1, 1, 0, BEQ,    3,   3,   'h804,   'h900,   0, 0,      1, 3,  0,  0);
    check_val("t6_wbr", 32'(w_br_cnt), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      vec("t6_wrap", 0, 1, 1, BEQ,    2,   2,   'h904,   'ha00,   0, 0,      1, 3, 16'(i), 0);
      check_val("t6_wbr", 32'(w_br_cnt), 32'(i % 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
